// File: rtl/clk_gen_ctrl.sv
// Four-channel programmable clock-waveform generator: each channel emits a divided
// square wave, either free-running or for a programmed number of toggles.
module clk_gen_ctrl #(
   parameter  int NUM_CH = 4,
   parameter  int DIV_W  = 8,
   parameter  int CNT_W  = 8,
   localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cfg_we,
   input  logic [CH_W-1:0]   cfg_ch,
   input  logic [DIV_W-1:0]  cfg_half,
   input  logic [CNT_W-1:0]  cfg_toggles,
   input  logic [NUM_CH-1:0] start,
   input  logic [NUM_CH-1:0] stop,
   output logic [NUM_CH-1:0] clk_out,
   output logic [NUM_CH-1:0] busy,
   output logic [NUM_CH-1:0] done
);

   typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

   state_t            r_state  [NUM_CH];
   logic [DIV_W-1:0]  r_half   [NUM_CH];
   logic [CNT_W-1:0]  r_tog    [NUM_CH];
   logic [DIV_W-1:0]  r_div    [NUM_CH];
   logic [DIV_W-1:0]  r_reload [NUM_CH];
   logic [CNT_W-1:0]  r_rem    [NUM_CH];
   logic [NUM_CH-1:0] r_clk;
   logic [NUM_CH-1:0] r_done;

   state_t            w_state_nxt  [NUM_CH];
   logic [DIV_W-1:0]  w_div_nxt    [NUM_CH];
   logic [DIV_W-1:0]  w_reload_nxt [NUM_CH];
   logic [CNT_W-1:0]  w_rem_nxt    [NUM_CH];
   logic [DIV_W-1:0]  w_act_half   [NUM_CH];
   logic [CNT_W-1:0]  w_act_tog    [NUM_CH];
   logic [DIV_W-1:0]  w_eff_m1     [NUM_CH];
   logic [NUM_CH-1:0] w_sel;
   logic [NUM_CH-1:0] w_clk_nxt;
   logic [NUM_CH-1:0] w_done_nxt;

   // r_reload latches the half-period at start so config writes during a run
   // only affect the next start; rem == 0 marks a free-running channel.
   always_comb begin
      for (int i = 0; i < NUM_CH; i++) begin
         w_sel[i]        = cfg_we && (cfg_ch == CH_W'(i));
         w_act_half[i]   = w_sel[i] ? cfg_half    : r_half[i];
         w_act_tog[i]    = w_sel[i] ? cfg_toggles : r_tog[i];
         w_eff_m1[i]     = (w_act_half[i] == '0) ? '0 : w_act_half[i] - DIV_W'(1);
         w_state_nxt[i]  = r_state[i];
         w_div_nxt[i]    = r_div[i];
         w_reload_nxt[i] = r_reload[i];
         w_rem_nxt[i]    = r_rem[i];
         w_clk_nxt[i]    = r_clk[i];
         w_done_nxt[i]   = 1'b0;
         case (r_state[i])
            IDLE: begin
               if (stop[i]) begin
                  w_clk_nxt[i] = 1'b0;
               end else if (start[i]) begin
                  w_state_nxt[i]  = RUN;
                  w_clk_nxt[i]    = 1'b0;
                  w_div_nxt[i]    = w_eff_m1[i];
                  w_reload_nxt[i] = w_eff_m1[i];
                  w_rem_nxt[i]    = w_act_tog[i];
               end
            end
            RUN: begin
               if (stop[i]) begin
                  w_state_nxt[i] = IDLE;
                  w_clk_nxt[i]   = 1'b0;
                  w_div_nxt[i]   = '0;
                  w_rem_nxt[i]   = '0;
               end else if (r_div[i] != '0) begin
                  w_div_nxt[i] = r_div[i] - DIV_W'(1);
               end else begin
                  w_clk_nxt[i] = ~r_clk[i];
                  w_div_nxt[i] = r_reload[i];
                  if (r_rem[i] != '0) begin
                     w_rem_nxt[i] = r_rem[i] - CNT_W'(1);
                     if (r_rem[i] == CNT_W'(1)) begin
                        w_state_nxt[i] = IDLE;
                        w_done_nxt[i]  = 1'b1;
                     end
                  end
               end
            end
            default: w_state_nxt[i] = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NUM_CH; i++) begin
            r_state[i]  <= IDLE;
            r_half[i]   <= DIV_W'(1);
            r_tog[i]    <= '0;
            r_div[i]    <= '0;
            r_reload[i] <= '0;
            r_rem[i]    <= '0;
         end
         r_clk  <= '0;
         r_done <= '0;
      end else begin
         for (int i = 0; i < NUM_CH; i++) begin
            r_state[i]  <= w_state_nxt[i];
            r_div[i]    <= w_div_nxt[i];
            r_reload[i] <= w_reload_nxt[i];
            r_rem[i]    <= w_rem_nxt[i];
            if (w_sel[i]) begin
               r_half[i] <= cfg_half;
               r_tog[i]  <= cfg_toggles;
            end
         end
         r_clk  <= w_clk_nxt;
         r_done <= w_done_nxt;
      end
   end

   always_comb begin
      for (int i = 0; i < NUM_CH; i++) begin
         busy[i] = (r_state[i] == RUN);
      end
   end

   assign clk_out = r_clk;
   assign done    = r_done;

endmodule

// File: tb/tb_clk_gen_ctrl.sv
// Directed bench for clk_gen_ctrl: expected toggle edges are queued at start time
// and popped as each clk_out transition is observed.
module tb_clk_gen_ctrl;

   logic       clk = 1'b0;
   logic       rst;
   logic       cfg_we;
   logic [1:0] cfg_ch;
   logic [7:0] cfg_half;
   logic [7:0] cfg_toggles;
   logic [3:0] start;
   logic [3:0] stop;
   logic [3:0] clk_out;
   logic [3:0] busy;
   logic [3:0] done;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;
   int e0;
   int snap;
   int done_cnt [4];
   int done_cyc [4];
   logic [31:0] exp_q [$];

   clk_gen_ctrl #(.NUM_CH(4), .DIV_W(8), .CNT_W(8)) dut (
      .clk         (clk),
      .rst         (rst),
      .cfg_we      (cfg_we),
      .cfg_ch      (cfg_ch),
      .cfg_half    (cfg_half),
      .cfg_toggles (cfg_toggles),
      .start       (start),
      .stop        (stop),
      .clk_out     (clk_out),
      .busy        (busy),
      .done        (done)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
      cyc++;
      for (int c = 0; c < 4; c++) begin
         if (done[c]) begin
            done_cnt[c]++;
            done_cyc[c] = cyc;
         end
      end
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic write_cfg(input int ch, input int h, input int t);
      cfg_we      = 1'b1;
      cfg_ch      = ch[1:0];
      cfg_half    = h[7:0];
      cfg_toggles = t[7:0];
      step();
      cfg_we = 1'b0;
   endtask

   task automatic pulse_start(input logic [3:0] m);
      start = m;
      step();
      start = '0;
   endtask

   task automatic push_toggles(input int base, input int h, input int n);
      for (int k = 1; k <= n; k++) exp_q.push_back(32'(base + k * h));
   endtask

   task automatic watch(input int ch, input int n);
      logic prev;
      logic [31:0] e;
      for (int k = 0; k < n; k++) begin
         prev = clk_out[ch];
         step();
         if (clk_out[ch] !== prev) begin
            if (exp_q.size() == 0) begin
               check("unexpected_toggle", 32'(cyc), 32'd0);
            end else begin
               e = exp_q.pop_front();
               check("toggle_cycle", 32'(cyc), e);
            end
         end
      end
   endtask

   task automatic drain_check(input string tag);
      check(tag, 32'(exp_q.size()), 32'd0);
      exp_q.delete();
   endtask

   initial begin
      rst = 1'b1; cfg_we = 1'b0; cfg_ch = '0; cfg_half = '0; cfg_toggles = '0;
      start = '0; stop = '0;
      for (int c = 0; c < 4; c++) begin done_cnt[c] = 0; done_cyc[c] = 0; end
      repeat (3) step();
      check("reset_clk_out", 32'(clk_out), 32'd0);
      check("reset_busy", 32'(busy), 32'd0);
      check("reset_done", 32'(done), 32'd0);
      rst = 1'b0;
      step();

      // ch0 free-running, half=5
      write_cfg(0, 5, 0);
      pulse_start(4'b0001);
      e0 = cyc;
      check("ch0_busy", 32'(busy[0]), 32'd1);
      push_toggles(e0, 5, 40);
      watch(0, 200);
      drain_check("ch0_queue");
      check("ch0_no_done", 32'(done_cnt[0]), 32'd0);
      check("ch0_still_busy", 32'(busy[0]), 32'd1);
      stop = 4'b0001; step(); stop = '0;
      check("ch0_stop_busy", 32'(busy[0]), 32'd0);
      check("ch0_stop_clk", 32'(clk_out[0]), 32'd0);

      // ch3 finite run, half=7, 10 toggles
      write_cfg(3, 7, 10);
      pulse_start(4'b1000);
      e0 = cyc;
      push_toggles(e0, 7, 10);
      watch(3, 80);
      drain_check("ch3_queue");
      check("ch3_done_cnt", 32'(done_cnt[3]), 32'd1);
      check("ch3_done_cyc", 32'(done_cyc[3]), 32'(e0 + 70));
      check("ch3_final_clk", 32'(clk_out[3]), 32'd0);
      check("ch3_busy", 32'(busy[3]), 32'd0);

      // ch1 stopped mid-run at E0+7, then restarted
      write_cfg(1, 3, 5);
      pulse_start(4'b0010);
      e0 = cyc;
      push_toggles(e0, 3, 2);
      watch(1, 6);
      stop = 4'b0010; step(); stop = '0;
      check("ch1_stop_clk", 32'(clk_out[1]), 32'd0);
      check("ch1_stop_busy", 32'(busy[1]), 32'd0);
      watch(1, 10);
      drain_check("ch1_stop_queue");
      check("ch1_no_done", 32'(done_cnt[1]), 32'd0);
      pulse_start(4'b0010);
      e0 = cyc;
      push_toggles(e0, 3, 5);
      watch(1, 20);
      drain_check("ch1_restart_queue");
      check("ch1_done_cyc", 32'(done_cyc[1]), 32'(e0 + 15));
      check("ch1_final_clk", 32'(clk_out[1]), 32'd1);

      // ch2 write bypass: config write and start in the same cycle
      cfg_we = 1'b1; cfg_ch = 2'd2; cfg_half = 8'd2; cfg_toggles = 8'd4; start = 4'b0100;
      step();
      cfg_we = 1'b0; start = '0;
      e0 = cyc;
      push_toggles(e0, 2, 4);
      watch(2, 10);
      drain_check("ch2_bypass_queue");
      check("ch2_bypass_done_cyc", 32'(done_cyc[2]), 32'(e0 + 8));
      check("ch2_bypass_final", 32'(clk_out[2]), 32'd0);

      // ch2 start+stop together from IDLE
      start = 4'b0100; stop = 4'b0100; step(); start = '0; stop = '0;
      check("ch2_ss_busy", 32'(busy[2]), 32'd0);
      watch(2, 5);
      drain_check("ch2_ss_queue");

      // ch2 start while busy is ignored, and a write during the run has no effect
      write_cfg(2, 2, 0);
      pulse_start(4'b0100);
      e0 = cyc;
      push_toggles(e0, 2, 10);
      watch(2, 4);
      start = 4'b0100; cfg_we = 1'b1; cfg_ch = 2'd2; cfg_half = 8'd6; cfg_toggles = 8'd1;
      watch(2, 1);
      start = '0; cfg_we = 1'b0;
      watch(2, 15);
      drain_check("ch2_busy_start_queue");
      check("ch2_busy_still", 32'(busy[2]), 32'd1);
      stop = 4'b0100; step(); stop = '0;
      check("ch2_busy_stopped", 32'(busy[2]), 32'd0);
      check("ch2_done_unchanged", 32'(done_cnt[2]), 32'd1);

      // ch2 cfg_half=0 behaves as H=1
      write_cfg(2, 0, 3);
      pulse_start(4'b0100);
      e0 = cyc;
      push_toggles(e0, 1, 3);
      watch(2, 6);
      drain_check("ch2_h0_queue");
      check("ch2_h0_done_cnt", 32'(done_cnt[2]), 32'd2);
      check("ch2_h0_done_cyc", 32'(done_cyc[2]), 32'(e0 + 3));
      check("ch2_h0_final", 32'(clk_out[2]), 32'd1);
      check("ch2_h0_busy", 32'(busy[2]), 32'd0);

      // all channels, reset mid-run
      write_cfg(0, 1, 4);
      write_cfg(1, 2, 0);
      write_cfg(2, 3, 6);
      write_cfg(3, 4, 0);
      snap = done_cnt[0] + done_cnt[1] + done_cnt[2] + done_cnt[3];
      pulse_start(4'b1111);
      check("all_busy", 32'(busy), 32'hf);
      repeat (2) step();
      rst = 1'b1; step(); rst = 1'b0;
      check("rst_clk_out", 32'(clk_out), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_no_done", 32'(done_cnt[0] + done_cnt[1] + done_cnt[2] + done_cnt[3]), 32'(snap));

      // config returned to half=1, toggles=0: free-running at H=1, never wraps
      pulse_start(4'b1111);
      check("post_rst_busy", 32'(busy), 32'hf);
      check("post_rst_clk0", 32'(clk_out), 32'd0);
      step();
      check("post_rst_clk1", 32'(clk_out), 32'hf);
      step();
      check("post_rst_clk2", 32'(clk_out), 32'd0);
      repeat (300) step();
      check("free_run_busy", 32'(busy), 32'hf);
      check("free_run_no_done", 32'(done_cnt[0] + done_cnt[1] + done_cnt[2] + done_cnt[3]), 32'(snap));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/clk_gen_ctrl.md
# clk_gen_ctrl

Synthesizable multi-channel clock-waveform controller that replaces the testbench-only ways of making clocks with one programmable block. There are four channels. Each channel produces a divided square wave from the system clock. Each channel runs either free-running ("forever" mode) or for a programmed number of toggles ("repeat" mode). The block sits between a register/config master and any logic that needs gated test clocks or clock enables, and it sequences start, stop and completion per channel.

## Interface
- NUM_CH, 4: number of independent channels.
- DIV_W, 8: width of the half-period field, counted in clk cycles.
- CNT_W, 8: width of the toggle-count field.

- clk  input  1  system clock; all logic is on its rising edge.
- rst  input  1  synchronous, active-high reset.
- cfg_we  input  1  config write strobe.
- cfg_ch  input  $clog2(NUM_CH)  channel selected by the write.
- cfg_half  input  DIV_W  half-period in clk cycles; 0 is treated as 1.
- cfg_toggles  input  CNT_W  number of output toggles; 0 means free-running.
- start  input  NUM_CH  per-channel start pulse.
- stop  input  NUM_CH  per-channel stop pulse.
- clk_out  output  NUM_CH  generated waveforms (registered).
- busy  output  NUM_CH  channel is running.
- done  output  NUM_CH  one-cycle pulse when a finite run completes.

## Operation
- Per-channel config registers are half_r and tog_r. Reset values: half_r=1, tog_r=0.
- A write updates only the selected channel's registers. A write is accepted at any time, including while the channel is busy.
- A write while busy affects only the next start; the running waveform is unchanged.
- Per-channel FSM has two states, IDLE and RUN. Internal state: div_cnt (DIV_W bits) and rem (CNT_W bits).
- IDLE -> RUN on start[i]:
  - clk_out[i] <= 0.
  - div_cnt <= eff_half-1, where eff_half = max(half,1).
  - rem <= toggles.
  - The values loaded are the active config. If cfg_we targets channel i in the same cycle, the cfg_* bus values are used (write bypass); otherwise half_r/tog_r are used.
- RUN, each cycle:
  - If div_cnt != 0, decrement div_cnt.
  - If div_cnt == 0, toggle clk_out[i] and reload div_cnt to eff_half-1.
  - On a toggle when tog != 0, decrement rem. If rem was 1, go to IDLE and pulse done[i] at the same edge.
- RUN -> IDLE on stop[i]: clk_out[i] <= 0, no done pulse, counters cleared.
- After a finite run, clk_out[i] holds its final level in IDLE. The final level is 1 if toggles is odd, 0 if even. It returns to 0 on the next start or on stop.
- start[i] while in RUN: ignored.
- stop[i] while in IDLE: forces clk_out[i]=0, no other effect.
- start[i] and stop[i] in the same cycle: stop wins.
  - From IDLE, the channel stays IDLE.
  - From RUN, the channel stops.
- Channels are fully independent. Any mix of simultaneous starts, stops and writes is legal.
- busy[i] = (state == RUN), registered.

## Timing
- Reset values: clk_out=0, busy=0, done=0, all FSMs IDLE, half_r=1, tog_r=0. Reset mid-run aborts every channel immediately with no done pulse.
- Start latency: start sampled at edge E0 gives busy=1 after E0.
- First toggle is visible after edge E0+H, where H = eff_half. Subsequent toggles follow every H cycles, so the output period is 2H clk cycles at 50% duty.
- Finite run of N toggles: the last toggle occurs at E0+N·H. At that same edge done=1 for exactly one cycle and busy drops to 0.
- Earliest restart: a start in the cycle after done is accepted. The back-to-back gap is one IDLE cycle.
- Stop latency: stop sampled at edge E gives busy=0 and clk_out=0 after E.
- Free-running: rem is never decremented and done is never asserted. tog_r=0 with CNT_W=8 must not wrap into a finite run.
- H=255 (max) and cfg_half=0 (gives H=1, output toggles every clk cycle) are both legal.

## Test plan
- After reset, write ch0 half=5, toggles=0; start[0] -> busy[0]=1; clk_out[0] period is 10 clk cycles for 200 cycles; done[0] never asserts.
- Write ch3 half=7, toggles=10; start[3] at E0 -> 10 toggles at E0+7k for k=1..10; done[3] is a single pulse at E0+70; clk_out[3] ends at 0; busy[3]=0.
- Start ch1 with half=3, toggles=5; assert stop[1] at E0+7 -> clk_out[1]=0 and busy[1]=0 after that edge; no done; later start restarts cleanly from 0.
- Same-cycle cases on ch2:
  - cfg_we with half=2 plus start -> run uses half=2.
  - start plus stop together from IDLE -> no run.
  - start while busy -> ignored; period unchanged.
- Write cfg_half=0, toggles=3 and start -> clk_out toggles every cycle; done is at E0+3; final level is 1.
- Run all four channels together (half 1/2/3/4, toggles 4/0/6/0) and assert rst mid-run -> every output 0, busy=0, no done, config back to half=1/toggles=0.
